// File: rtl/sensor_poll_scheduler_if.sv
// Shared sensor bus: one request/select towards the front-ends, one ack/data back.
interface sensor_poll_scheduler_if #(
    parameter int DATA_W = 16
) ();
    logic              bus_req;
    logic [2:0]        bus_sel;
    logic              bus_ack;
    logic [DATA_W-1:0] bus_data;

    modport master (output bus_req, output bus_sel, input bus_ack, input bus_data);
    modport slave  (input bus_req, input bus_sel, output bus_ack, output bus_data);
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Round-robin poller: walks the sensor mask once per round, issues one bus request
// per enabled sensor and reports each sample as a one-hot valid pulse.
module sensor_poll_scheduler #(
    parameter int NUM_SENSORS = 5,
    parameter int DATA_W      = 16,
    parameter int TIMER_W     = 16,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic [TIMER_W-1:0]         poll_interval,
    input  logic [NUM_SENSORS-1:0]     sensor_mask,
    input  logic [NUM_SENSORS-1:0]     err_clr,
    sensor_poll_scheduler_if.master    bus,
    output logic [NUM_SENSORS-1:0]     sample_valid,
    output logic [DATA_W-1:0]          sample_data,
    output logic [NUM_SENSORS-1:0]     timeout_err,
    output logic                       round_done,
    output logic                       busy
);
    localparam int PTR_W  = 3;
    localparam int TCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_SCAN, S_REQ, S_NEXT} state_t;

    state_t               state;
    logic [PTR_W-1:0]     ptr;
    logic [TIMER_W-1:0]   icnt;
    logic [TIMER_W-1:0]   wait_last;
    logic [TCNT_W-1:0]    tcnt;

    logic [TIMER_W-1:0]   interval_last;
    logic                 last_ptr;
    logic                 tmo_hit;
    logic [NUM_SENSORS-1:0] err_set;

    // poll_interval of 0 behaves like 1
    assign interval_last = (poll_interval == '0) ? '0 : poll_interval - TIMER_W'(1);
    assign last_ptr      = (ptr == PTR_W'(NUM_SENSORS - 1));
    assign tmo_hit       = (state == S_REQ) && !bus.bus_ack && (tcnt == TCNT_W'(TIMEOUT_CYC - 1));
    assign err_set       = tmo_hit ? (NUM_SENSORS'(1) << ptr) : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= S_IDLE;
            ptr          <= '0;
            icnt         <= '0;
            wait_last    <= '0;
            tcnt         <= '0;
            bus.bus_req  <= 1'b0;
            bus.bus_sel  <= '0;
            sample_valid <= '0;
            sample_data  <= '0;
            round_done   <= 1'b0;
            busy         <= 1'b0;
        end else begin
            sample_valid <= '0;
            round_done   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state     <= S_WAIT;
                        icnt      <= '0;
                        wait_last <= interval_last;
                    end
                end
                S_WAIT: begin
                    if (!enable) begin
                        state <= S_IDLE;
                    end else if (icnt == wait_last) begin
                        state <= S_SCAN;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else begin
                        icnt <= icnt + TIMER_W'(1);
                    end
                end
                S_SCAN: begin
                    if (sensor_mask[ptr]) begin
                        state       <= S_REQ;
                        tcnt        <= '0;
                        bus.bus_req <= 1'b1;
                        bus.bus_sel <= ptr;
                    end else begin
                        state      <= S_NEXT;
                        round_done <= last_ptr;
                    end
                end
                S_REQ: begin
                    // an ack on the final allowed cycle still wins over the timeout
                    if (bus.bus_ack) begin
                        state             <= S_NEXT;
                        bus.bus_req       <= 1'b0;
                        sample_data       <= bus.bus_data;
                        sample_valid[ptr] <= 1'b1;
                        round_done        <= last_ptr;
                    end else if (tmo_hit) begin
                        state       <= S_NEXT;
                        bus.bus_req <= 1'b0;
                        round_done  <= last_ptr;
                    end else begin
                        tcnt <= tcnt + TCNT_W'(1);
                    end
                end
                S_NEXT: begin
                    if (last_ptr) begin
                        busy <= 1'b0;
                        if (enable) begin
                            state     <= S_WAIT;
                            icnt      <= '0;
                            wait_last <= interval_last;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        ptr   <= ptr + PTR_W'(1);
                        state <= S_SCAN;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // set beats a coincident write-1-to-clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) timeout_err <= '0;
        else        timeout_err <= (timeout_err & ~err_clr) | err_set;
    end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Randomized bench: per-round timeline model built from per-sensor ack delays and mask.
module tb_sensor_poll_scheduler;
    localparam int NS = 5;
    localparam int DW = 16;
    localparam int TW = 16;
    localparam int TO = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [TW-1:0] poll_interval;
    logic [NS-1:0] sensor_mask;
    logic [NS-1:0] err_clr;
    logic [NS-1:0] sample_valid;
    logic [DW-1:0] sample_data;
    logic [NS-1:0] timeout_err;
    logic          round_done;
    logic          busy;

    sensor_poll_scheduler_if #(.DATA_W(DW)) bus_if ();

    sensor_poll_scheduler #(
        .NUM_SENSORS(NS), .DATA_W(DW), .TIMER_W(TW), .TIMEOUT_CYC(TO)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .poll_interval(poll_interval),
        .sensor_mask  (sensor_mask),
        .err_clr      (err_clr),
        .bus          (bus_if),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .timeout_err  (timeout_err),
        .round_done   (round_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int            n_chk  = 0;
    int            n_fail = 0;
    int            pl_dly [NS];   // ack on this REQ cycle index; >= TO means never
    logic [DW-1:0] pl_dat [NS];
    logic [NS-1:0] exp_err;
    logic [DW-1:0] exp_data;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int gap_of(input logic [TW-1:0] pi);
        return (pi == '0) ? 1 : int'(pi);
    endfunction

    // Count idle (WAIT) cycles until the round starts; bounded.
    task automatic wait_start(input int exp_gap);
        int n;
        n = 0;
        while (busy !== 1'b1 && n < 200) begin
            chk("wait_req", bus_if.bus_req, 0);
            chk("wait_valid", sample_valid, 0);
            chk("wait_rdone", round_done, 0);
            n++;
            step();
        end
        chk("gap", n, exp_gap);
    endtask

    // Entered on the SCAN cycle of sensor 0; leaves on the cycle after the last NEXT.
    task automatic play_round(input logic [NS-1:0] mask, input logic [NS-1:0] coinc_clr,
                              input int drop_at);
        logic [NS-1:0] exp_valid;
        int            len;
        sensor_mask = mask;
        for (int j = 0; j < NS; j++) begin
            chk("scan_busy", busy, 1);
            chk("scan_req", bus_if.bus_req, 0);
            chk("scan_valid", sample_valid, 0);
            chk("scan_rdone", round_done, 0);
            bus_if.bus_ack  = 1'($urandom);
            bus_if.bus_data = DW'($urandom);
            step();
            bus_if.bus_ack = 1'b0;
            exp_valid = '0;
            if (mask[j]) begin
                len = (pl_dly[j] < TO) ? pl_dly[j] + 1 : TO;
                for (int k = 0; k < len; k++) begin
                    chk("req", bus_if.bus_req, 1);
                    chk("sel", bus_if.bus_sel, j);
                    chk("req_busy", busy, 1);
                    chk("req_valid", sample_valid, 0);
                    chk("req_data", sample_data, exp_data);
                    chk("req_err", timeout_err, exp_err);
                    if (j == drop_at && k == 0) enable = 1'b0;
                    bus_if.bus_ack  = (k == pl_dly[j]);
                    bus_if.bus_data = (k == pl_dly[j]) ? pl_dat[j] : DW'($urandom);
                    err_clr = (k == len - 1 && pl_dly[j] >= TO) ? coinc_clr : '0;
                    step();
                    bus_if.bus_ack = 1'b0;
                    err_clr = '0;
                end
                if (pl_dly[j] < TO) begin
                    exp_data  = pl_dat[j];
                    exp_valid = NS'(1) << j;
                end else begin
                    exp_err = (exp_err & ~coinc_clr) | (NS'(1) << j);
                end
            end
            chk("next_req", bus_if.bus_req, 0);
            chk("next_busy", busy, 1);
            chk("valid", sample_valid, exp_valid);
            chk("data", sample_data, exp_data);
            chk("err", timeout_err, exp_err);
            chk("rdone", round_done, (j == NS - 1));
            bus_if.bus_ack  = 1'($urandom);
            bus_if.bus_data = DW'($urandom);
            step();
            bus_if.bus_ack = 1'b0;
        end
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; poll_interval = TW'(4);
        sensor_mask = '0; err_clr = '0;
        bus_if.bus_ack = 1'b0; bus_if.bus_data = '0;
        exp_err = '0; exp_data = '0;
        #2;
        chk("rst_req", bus_if.bus_req, 0);
        chk("rst_sel", bus_if.bus_sel, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_rdone", round_done, 0);
        chk("rst_busy", busy, 0);
        step(); step();
        reset = 1'b1;
        repeat (3) begin
            step();
            chk("off_busy", busy, 0);
            chk("off_req", bus_if.bus_req, 0);
        end

        // basic round: ack on the third REQ cycle, data 0x0100+i
        for (int i = 0; i < NS; i++) begin
            pl_dly[i] = 2;
            pl_dat[i] = DW'(16'h0100 + i);
        end
        enable = 1'b1;
        step();
        wait_start(4);
        play_round(5'b11111, '0, -1);
        wait_start(4);

        // mask skip and an all-zero mask
        for (int i = 0; i < NS; i++) pl_dat[i] = DW'($urandom);
        play_round(5'b10100, '0, -1);
        wait_start(4);
        play_round(5'b00000, '0, -1);
        wait_start(4);

        // timeout on sensor 1, then ack on the final allowed cycle
        for (int i = 0; i < NS; i++) pl_dly[i] = 1;
        pl_dly[1] = TO;
        play_round(5'b11111, '0, -1);
        wait_start(4);
        pl_dly[1] = TO - 1;
        play_round(5'b11111, '0, -1);

        // clear in an idle cycle, then clear coincident with a fresh timeout
        err_clr = 5'b00010;
        step();
        err_clr = '0;
        exp_err = exp_err & ~5'b00010;
        chk("clr_err", timeout_err, exp_err);
        wait_start(3);
        pl_dly[1] = TO;
        play_round(5'b11111, 5'b00010, -1);
        wait_start(4);

        // randomized rounds
        repeat (12) begin
            logic [NS-1:0] m;
            logic [TW-1:0] pi;
            m  = NS'($urandom);
            pi = TW'($urandom_range(6, 0));
            poll_interval = pi;
            for (int i = 0; i < NS; i++) begin
                pl_dly[i] = int'($urandom_range(TO + 1, 0));
                pl_dat[i] = DW'($urandom);
            end
            play_round(m, NS'($urandom), -1);
            wait_start(gap_of(pi));
        end

        // enable drop during sensor 2's request
        for (int i = 0; i < NS; i++) begin
            pl_dly[i] = 1;
            pl_dat[i] = DW'($urandom) | DW'(1);
        end
        pl_dly[3] = TO;
        pl_dat[4] = 16'hBEEF;
        play_round(5'b11111, '0, 2);
        repeat (20) begin
            chk("drop_busy", busy, 0);
            chk("drop_req", bus_if.bus_req, 0);
            step();
        end

        // async reset in the middle of a request
        enable = 1'b1;
        step();
        wait_start(gap_of(poll_interval));
        sensor_mask = '1;
        step();
        chk("pre_rst_req", bus_if.bus_req, 1);
        chk("pre_rst_err", timeout_err, exp_err);
        #2 reset = 1'b0;
        #1;
        chk("arst_req", bus_if.bus_req, 0);
        chk("arst_busy", busy, 0);
        chk("arst_err", timeout_err, 0);
        chk("arst_data", sample_data, 0);
        chk("arst_valid", sample_valid, 0);
        exp_err = '0;
        exp_data = '0;
        step(); step();
        reset = 1'b1;
        step();
        wait_start(gap_of(poll_interval));
        for (int i = 0; i < NS; i++) begin
            pl_dly[i] = int'($urandom_range(TO + 1, 0));
            pl_dat[i] = DW'($urandom);
        end
        play_round(5'b11111, '0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sensor_poll_scheduler.md
Name: sensor_poll_scheduler

Overview:
- Round-robin poll sequencer that shares one sensor bus among up to NUM_SENSORS sensor front-ends.
- Per round it requests a sample from each enabled sensor over a req/ack handshake and returns each sample as a one-hot valid pulse plus data. The outputs feed the per-sensor valid/data inputs of sensor_controller.
- poll_interval, sensor_mask and err_clr come from the CSR block. Timeout errors are sticky and readable back through CSR.

Parameters:
- NUM_SENSORS, 5, number of polled sensors (index 0=temp, 1=humidity, 2=dew, 3=moisture, 4=water level).
- DATA_W, 16, sample width.
- TIMER_W, 16, poll_interval counter width.
- TIMEOUT_CYC, 255, maximum cycles bus_req is held without bus_ack (must be ≥1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- enable  in  1  run polling rounds while high.
- poll_interval  in  TIMER_W  idle cycles between rounds; 0 is treated as 1.
- sensor_mask  in  NUM_SENSORS  bit i=1 polls sensor i.
- err_clr  in  NUM_SENSORS  write-1-to-clear for timeout_err.
- bus_req  out  1  sample request to the shared sensor bus.
- bus_sel  out  3  index of the requested sensor.
- bus_ack  in  1  sample ready; bus_data valid in the same cycle.
- bus_data  in  DATA_W  sample from the selected sensor.
- sample_valid  out  NUM_SENSORS  one-hot, one-cycle pulse per captured sample.
- sample_data  out  DATA_W  last captured sample; held between captures.
- timeout_err  out  NUM_SENSORS  sticky per-sensor timeout flag.
- round_done  out  1  one-cycle pulse at the end of each round.
- busy  out  1  high in every state except IDLE and WAIT.

Behaviour:
- Reset (async, reset=0):
  - State goes to IDLE; ptr, interval counter and timeout counter go to 0.
  - All outputs go to 0: bus_req, bus_sel, sample_valid, sample_data, timeout_err, round_done, busy.
  - Applies mid-transaction with no handshake completion.
- All outputs are registered.
- IDLE:
  - If enable=1, go to WAIT with icnt=0.
- WAIT:
  - icnt increments each cycle.
  - When icnt == max(poll_interval,1)-1, go to SCAN with ptr=0.
  - If enable=0, go to IDLE.
- SCAN (one cycle per index):
  - If sensor_mask[ptr]=1, go to REQ with tcnt=0.
  - Otherwise go to NEXT.
  - sensor_mask is sampled per index as the pointer reaches it.
- REQ:
  - bus_req=1 and bus_sel=ptr are held stable for the whole state.
  - bus_ack=1 at a clock edge: bus_data is registered into sample_data, and sample_valid[ptr]=1 in the following cycle only. Go to NEXT.
  - Otherwise tcnt increments.
  - If tcnt == TIMEOUT_CYC-1 with no ack: set timeout_err[ptr], then go to NEXT. bus_req has then been high for exactly TIMEOUT_CYC cycles.
  - An ack on the final cycle is a capture, not a timeout.
- NEXT:
  - bus_req=0.
  - If ptr == NUM_SENSORS-1: pulse round_done; go to WAIT (icnt=0) if enable=1, else IDLE.
  - Otherwise ptr++ and go to SCAN.
- bus_ack outside REQ is ignored.
- enable falling mid-round: the current REQ completes (ack or timeout) and the round is finished, then the block goes to IDLE. A REQ is never abandoned.
- Latency:
  - bus_ack edge → sample_valid: 1 cycle.
  - Masked-off sensor: 2 cycles (SCAN + NEXT).
  - All-zero mask: round takes 2*NUM_SENSORS cycles and still pulses round_done.
- timeout_err: if err_clr[i] and a set of bit i occur in the same cycle, set wins. Clear takes effect on the next edge.
- poll_interval or sensor_mask changes take effect at the next WAIT entry or SCAN index respectively. There are no glitches on bus_sel.

Test Plan:
- Basic round: reset release, enable=1, poll_interval=4, mask=5'b11111, ack 2 cycles after each bus_req with data 16'h0100+i → sample_valid pulses 00001,00010,…,10000 with sample_data 0x0100…0x0104, round_done once, then a 4-cycle gap before the next bus_req.
- Mask skip: mask=5'b10100 → bus_sel 2 then 4 only; exactly 2 sample_valid pulses; round_done after sensor 4; bus_req never asserted for 0, 1, 3.
- Timeout: TIMEOUT_CYC=8, sensor 1 never acks → bus_req high exactly 8 cycles with bus_sel=1, timeout_err=5'b00010, no sample_valid[1], round continues to sensor 2. Ack on 8th cycle in a rerun → capture, no error.
- Sticky/clear: timeout_err[1] set; err_clr=5'b00010 in a non-timeout cycle → bit clears next edge; err_clr coincident with a new timeout on sensor 1 → bit remains 1.
- Enable drop mid-REQ: deassert enable while bus_req is high on sensor 2 → ack accepted, sensors 3–4 still polled, round_done, then IDLE with busy=0 and no further bus_req.
- Async reset mid-REQ: reset=0 while bus_req=1 → bus_req, busy, timeout_err and sample_data are 0 without waiting for a clock edge. After release with enable=1, the next round starts from sensor 0.
